// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch/run-control block of the 9-bit core.
package fetch_ctrl_pkg;

  localparam int DEF_PW = 10;
  localparam logic [8:0] ACK_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus between fetch_ctrl (slave) and the testbench/decoder/register side (master).
interface fetch_ctrl_if #(
  parameter int PW = 10,
  parameter int W  = 8,
  parameter int CW = 16
) ();
  import fetch_ctrl_pkg::*;

  // Start/Done handshake: master raises Start (level) for >=1 cycle, then drops it;
  // the program runs from the cycle after Start is seen low. Done stays high
  // until the cycle after Start is seen high again. Start during RUN is ignored.
  logic          Start;
  logic [PW-1:0] StartAddr;
  logic          BranchUp;
  logic          BranchDown;
  logic          Ack;
  logic [W-1:0]  PCTarget;
  logic [PW-1:0] ProgCtr;
  logic          Running;
  logic          Done;
  logic [CW-1:0] CycleCount;
  fetch_state_t  FetchState;

  modport master (
    output Start, StartAddr, BranchUp, BranchDown, Ack, PCTarget,
    input  ProgCtr, Running, Done, CycleCount, FetchState
  );

  modport slave (
    input  Start, StartAddr, BranchUp, BranchDown, Ack, PCTarget,
    output ProgCtr, Running, Done, CycleCount, FetchState
  );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module fetch_ctrl_sat_counter #(
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and Start/Done run control; drives the instruction ROM address.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PW = DEF_PW,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic Clk,
  input  logic Reset,
  fetch_ctrl_if.slave bus
);

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [W-1:0]  target;
  logic [PW-1:0] target_ext;
  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cycle_count;

  assign target     = bus.PCTarget;
  assign target_ext = PW'(target);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = ARMED;
          cnt_clr = 1'b1;
        end
      end
      ARMED: begin
        pc_d    = bus.StartAddr;
        cnt_clr = 1'b1;
        if (!bus.Start) state_d = RUN;
      end
      RUN: begin
        cnt_en = 1'b1;
        // Ack outranks BranchDown: the decoder raises both on the done instruction.
        if (bus.Ack) begin
          state_d = DONE;
        end else if (bus.BranchDown) begin
          pc_d = pc_q + target_ext;
        end else if (bus.BranchUp) begin
          pc_d = pc_q - target_ext;
        end else begin
          pc_d = pc_q + PW'(1);
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_d = ARMED;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fetch_ctrl_sat_counter #(.CW(CW)) u_cycle_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cycle_count)
  );

  assign bus.ProgCtr    = pc_q;
  assign bus.Running    = (state_q == RUN);
  assign bus.Done       = (state_q == DONE);
  assign bus.CycleCount = cycle_count;
  assign bus.FetchState = state_q;

endmodule
